// File: rtl/b_resp_arbiter.sv
// Round-robin arbiter that merges NUM_SRC show-ahead write-response FIFOs
// onto one AXI B channel through a single registered output stage.
module b_resp_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*ID_WIDTH-1:0]   src_BID,
  input  logic [NUM_SRC*2-1:0]          src_BRESP,
  output logic [NUM_SRC-1:0]            src_pop,
  output logic [ID_WIDTH-1:0]           BID,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  output logic [$clog2(NUM_SRC)-1:0]    grant_src
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_t;

  stage_t              state;
  stage_t              state_next;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [ID_WIDTH-1:0] win_bid;
  logic [1:0]          win_resp;
  logic [NUM_SRC-1:0]  req;
  logic                free;
  logic                grant;

  assign req    = ~src_empty;
  assign free   = (state == EMPTY) || BREADY;
  assign grant  = free && win_found;
  assign BVALID = (state == FULL);

  // Pick the first requester at or above rr_ptr, else wrap to the lowest requester below it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_bid   = '0;
    win_resp  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && req[i] && (IDX_W'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_bid   = src_BID[i*ID_WIDTH +: ID_WIDTH];
        win_resp  = src_BRESP[i*2 +: 2];
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_bid   = src_BID[i*ID_WIDTH +: ID_WIDTH];
        win_resp  = src_BRESP[i*2 +: 2];
      end
    end
  end

  // One-hot pop of the winner, suppressed while reset is held.
  always_comb begin
    src_pop = '0;
    if (grant && !rst) begin
      src_pop[win_idx] = 1'b1;
    end
  end

  // Output stage refills on a grant, empties when free with nothing to load, else holds.
  always_comb begin
    state_next = state;
    if (free) begin
      state_next = grant ? FULL : EMPTY;
    end
  end

  // Output stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winning response and move the round-robin pointer past the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BID       <= '0;
      BRESP     <= '0;
      grant_src <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      BID       <= win_bid;
      BRESP     <= win_resp;
      grant_src <= win_idx;
      if (win_idx == IDX_W'(NUM_SRC - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= win_idx + 1'b1;
      end
    end
  end

endmodule
